writeback_stage: RTL and testbench

- Final pipeline stage and the write side of the register-file port that the decode stage reads.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Waits for variable-latency data-memory load returns.
- Selects ALU, load or link data, applies byte extraction and extension, and drives d/rd/rwe_wb into the register file, one registered write per instruction.

---
 rtl/writeback_stage.sv | 171 +++++++++++++++++
 tb/tb_writeback_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Last pipeline stage. This is the write side of the register file that the
//   decode stage reads. It takes retiring instructions from the memory stage
//   over a valid/ready handshake. For a load it waits, for a bounded number of
//   cycles, until the data memory returns the word. It then picks the ALU,
//   load or link value, formats byte loads, and issues one registered write
//   per instruction.
//
// Parameters
//   DM_TIMEOUT  cycles allowed in WAIT_DM before a load is abandoned (1..255)
//   LINK_REG    destination register for JAL-style links
//
// Ports
//   clock, reset_n      stage clock; asynchronous active-low reset
//   in_valid/in_ready   handshake with the memory stage
//   in_rwe, in_rwd      writes regfile / data comes from DMEM
//   in_rdst, in_link    rd-vs-rt select / write pc+8
//   in_rt, in_rdf       register fields
//   in_pc, in_alu       instruction PC / ALU result (bits [1:0] = byte offset)
//   in_dm_byte/_signed  byte load / sign-extend the byte
//   dm_rvalid, dm_rdata load return
//   d, rd, rwe_wb       register-file write index, data, enable pulse
//   stall               high while waiting for load data
//   dm_err              sticky load-timeout flag
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DM_TIMEOUT = 16,
    parameter int LINK_REG   = 31
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rwe,
    input  logic        in_rwd,
    input  logic        in_rdst,
    input  logic        in_link,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rdf,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu,
    input  logic        in_dm_byte,
    input  logic        in_dm_signed,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  d,
    output logic [31:0] rd,
    output logic        rwe_wb,
    output logic        stall,
    output logic        dm_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DM = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Everything a pending load needs once its data arrives.
    typedef struct packed {
        logic [4:0] dst;
        logic       rwe;
        logic       byte_ld;
        logic       sgn;
        logic [1:0] off;
    } ld_ctx_t;

    localparam logic [7:0] CNT_LAST = 8'(DM_TIMEOUT - 1);

    state_t     state;
    ld_ctx_t    ctx;
    logic [7:0] cnt;

    logic        xfer;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] alu_val;
    logic [31:0] ld_val;
    logic [3:0][7:0] word_lanes;
    logic [7:0]  lane;

    // Ready depends on the registered state only, so it has no
    // combinational path back to in_valid.
    assign in_ready = (state != WAIT_DM);
    assign xfer     = in_valid & in_ready;
    assign is_load  = in_rwd & in_rwe;

    // A link with the rt select defaults to the link register. JALR names
    // its own rd.
    always_comb begin
        dest = in_rdst ? in_rdf : in_rt;
        if (in_link && !in_rdst)
            dest = 5'(LINK_REG);
    end

    assign alu_val = in_link ? (in_pc + 32'd8) : in_alu;

    // Byte lanes are big-endian. Offset 0 selects the most significant
    // byte, which is lane 3 in the packed view.
    assign word_lanes = dm_rdata;
    assign lane       = word_lanes[2'd3 - ctx.off];

    always_comb begin
        ld_val = dm_rdata;
        if (ctx.byte_ld)
            ld_val = {{24{ctx.sgn & lane[7]}}, lane};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            ctx    <= '0;
            cnt    <= '0;
            d      <= '0;
            rd     <= '0;
            rwe_wb <= 1'b0;
            stall  <= 1'b0;
            dm_err <= 1'b0;
        end else begin
            rwe_wb <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (xfer) begin
                        if (is_load) begin
                            state <= WAIT_DM;
                            stall <= 1'b1;
                            cnt   <= '0;
                            ctx   <= '{dst:     dest,
                                       rwe:     in_rwe,
                                       byte_ld: in_dm_byte,
                                       sgn:     in_dm_signed,
                                       off:     in_alu[1:0]};
                        end else begin
                            // Stores and other non-writers still commit,
                            // but they never raise the enable.
                            state  <= COMMIT;
                            d      <= dest;
                            rd     <= alu_val;
                            rwe_wb <= in_rwe && (dest != 5'd0);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_DM: begin
                    // Data arriving on the final count takes priority
                    // over the timeout.
                    if (dm_rvalid) begin
                        state  <= COMMIT;
                        stall  <= 1'b0;
                        d      <= ctx.dst;
                        rd     <= ld_val;
                        rwe_wb <= ctx.rwe && (ctx.dst != 5'd0);
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        stall  <= 1'b0;
                        dm_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_rwe, in_rwd, in_rdst, in_link;
    logic [4:0]  in_rt, in_rdf;
    logic [31:0] in_pc, in_alu;
    logic        in_dm_byte, in_dm_signed, dm_rvalid;
    logic [31:0] dm_rdata;
    logic [4:0]  d;
    logic [31:0] rd;
    logic        rwe_wb, stall, dm_err;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_stage #(.DM_TIMEOUT(TO), .LINK_REG(31)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rwe(in_rwe), .in_rwd(in_rwd), .in_rdst(in_rdst), .in_link(in_link),
        .in_rt(in_rt), .in_rdf(in_rdf), .in_pc(in_pc), .in_alu(in_alu),
        .in_dm_byte(in_dm_byte), .in_dm_signed(in_dm_signed),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .d(d), .rd(rd), .rwe_wb(rwe_wb), .stall(stall), .dm_err(dm_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; in_rwe = 0; in_rwd = 0; in_rdst = 0; in_link = 0;
        in_rt = 0; in_rdf = 0; in_pc = 0; in_alu = 0;
        in_dm_byte = 0; in_dm_signed = 0; dm_rvalid = 0; dm_rdata = 0;
    endtask

    // Issue a load to rt=dst, return data after 'lat' WAIT_DM cycles
    // (lat=0 means never). Checks the stall/ready window along the way.
    task automatic do_load(input string name, input logic [4:0] dst, input logic byt,
                           input logic sgn, input logic [1:0] off,
                           input logic [31:0] data, input int lat);
        clear_in();
        in_valid = 1; in_rwe = 1; in_rwd = 1; in_rt = dst; in_rdf = 5'd30;
        in_alu = {30'h0000_1000, off}; in_dm_byte = byt; in_dm_signed = sgn;
        step();
        clear_in();
        for (int i = 0; i < ((lat == 0) ? TO : lat); i++) begin
            chk({name, " stall"}, 32'(stall), 32'd1);
            chk({name, " in_ready"}, 32'(in_ready), 32'd0);
            chk({name, " no early write"}, 32'(rwe_wb), 32'd0);
            if (lat != 0 && i == lat - 1) begin
                dm_rvalid = 1; dm_rdata = data;
            end
            step();
        end
        dm_rvalid = 0;
    endtask

    typedef struct {
        logic        rwe, rdst, link;
        logic [4:0]  rt, rdf;
        logic [31:0] pc, alu;
        logic [4:0]  exp_d;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic        chk_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //            rwe rdst link rt  rdf  pc            alu           d   rd            we cd
        vecs[0] = '{1, 1, 0, 5'd0, 5'd5, 32'h0000_0100, 32'h0000_0007, 5'd5,  32'h0000_0007, 1, 1}; // ADD
        vecs[1] = '{1, 0, 1, 5'd6, 5'd0, 32'h0040_0010, 32'h0000_DEAD, 5'd31, 32'h0040_0018, 1, 1}; // JAL
        vecs[2] = '{1, 1, 1, 5'd0, 5'd9, 32'h0040_0020, 32'h0000_1234, 5'd9,  32'h0040_0028, 1, 1}; // JALR
        vecs[3] = '{1, 0, 0, 5'd0, 5'd3, 32'h0000_0000, 32'h0000_0055, 5'd0,  32'h0000_0055, 0, 1}; // ADDI r0
        vecs[4] = '{0, 0, 0, 5'd8, 5'd0, 32'h0000_0000, 32'h0000_1000, 5'd0,  32'h0000_0000, 0, 0}; // SW
        vecs[5] = '{1, 0, 0, 5'd1, 5'd0, 32'h0000_0000, 32'h0000_00A0, 5'd1,  32'h0000_00A0, 1, 1};
        vecs[6] = '{1, 0, 0, 5'd2, 5'd0, 32'h0000_0000, 32'h0000_00A1, 5'd2,  32'h0000_00A1, 1, 1};
        vecs[7] = '{1, 0, 0, 5'd3, 5'd0, 32'h0000_0000, 32'h0000_00A2, 5'd3,  32'h0000_00A2, 1, 1};
        vecs[8] = '{1, 0, 0, 5'd4, 5'd0, 32'h0000_0000, 32'h0000_00A3, 5'd4,  32'h0000_00A3, 1, 1};
        vecs[9] = '{1, 0, 1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'h0000_0000, 5'd31, 32'h0000_0004, 1, 1}; // JAL wrap

        clear_in();
        reset_n = 0;
        #12;
        chk("reset d", 32'(d), 0);
        chk("reset rd", rd, 0);
        chk("reset rwe_wb", 32'(rwe_wb), 0);
        chk("reset stall", 32'(stall), 0);
        chk("reset dm_err", 32'(dm_err), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        reset_n = 1;
        step();

        // Back-to-back stream, one instruction per cycle.
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 1);
            in_valid = 1; in_rwd = 0;
            in_rwe = vecs[i].rwe; in_rdst = vecs[i].rdst; in_link = vecs[i].link;
            in_rt = vecs[i].rt; in_rdf = vecs[i].rdf; in_pc = vecs[i].pc; in_alu = vecs[i].alu;
            step();
            chk($sformatf("vec%0d rwe_wb", i), 32'(rwe_wb), 32'(vecs[i].exp_we));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d d", i), 32'(d), 32'(vecs[i].exp_d));
                chk($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
            end
        end

        // Idle; a stray dm_rvalid outside WAIT_DM must be ignored.
        clear_in();
        dm_rvalid = 1; dm_rdata = 32'hCAFE_F00D;
        step();
        chk("idle rwe_wb", 32'(rwe_wb), 0);
        chk("idle rd hold", rd, 32'h0000_0004);
        chk("idle d hold", 32'(d), 31);
        dm_rvalid = 0;

        // LB / LBU at offset 2, data three cycles after acceptance.
        do_load("LB", 5'd7, 1, 1, 2'd2, 32'h1122_8344, 3);
        chk("LB rd", rd, 32'hFFFF_FF83);
        chk("LB d", 32'(d), 7);
        chk("LB rwe_wb", 32'(rwe_wb), 1);
        chk("LB stall off", 32'(stall), 0);
        step();
        chk("LB pulse ends", 32'(rwe_wb), 0);

        do_load("LBU", 5'd7, 1, 0, 2'd2, 32'h1122_8344, 3);
        chk("LBU rd", rd, 32'h0000_0083);
        chk("LBU rwe_wb", 32'(rwe_wb), 1);

        do_load("LB0", 5'd10, 1, 1, 2'd0, 32'h7F22_8344, 1);
        chk("LB off0 rd", rd, 32'h0000_007F);
        do_load("LBU3", 5'd11, 1, 0, 2'd3, 32'h1122_8380, 2);
        chk("LBU off3 rd", rd, 32'h0000_0080);
        do_load("LW", 5'd12, 0, 0, 2'd1, 32'hDEAD_BEEF, 1);
        chk("LW rd", rd, 32'hDEAD_BEEF);
        chk("LW d", 32'(d), 12);

        // Data on the final permitted cycle wins over the timeout.
        do_load("LWlast", 5'd13, 0, 0, 2'd0, 32'h1357_9BDF, TO);
        chk("last-count rd", rd, 32'h1357_9BDF);
        chk("last-count rwe_wb", 32'(rwe_wb), 1);
        chk("last-count dm_err", 32'(dm_err), 0);

        // No data at all: abandon, flag error, no write.
        do_load("LWto", 5'd14, 0, 0, 2'd0, 32'h0, 0);
        chk("timeout dm_err", 32'(dm_err), 1);
        chk("timeout rwe_wb", 32'(rwe_wb), 0);
        chk("timeout in_ready", 32'(in_ready), 1);
        chk("timeout stall", 32'(stall), 0);
        chk("timeout d hold", 32'(d), 13);
        step();
        chk("dm_err sticky", 32'(dm_err), 1);

        // Async reset in the middle of a load.
        clear_in();
        in_valid = 1; in_rwe = 1; in_rwd = 1; in_rt = 5'd15;
        step();
        clear_in();
        step();
        chk("pre-reset stall", 32'(stall), 1);
        #2 reset_n = 0;
        #1;
        chk("async d", 32'(d), 0);
        chk("async rd", rd, 0);
        chk("async stall", 32'(stall), 0);
        chk("async dm_err", 32'(dm_err), 0);
        chk("async in_ready", 32'(in_ready), 1);
        #2 reset_n = 1;
        dm_rvalid = 1; dm_rdata = 32'h2468_ACE0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("late rvalid we %0d", i), 32'(rwe_wb), 0);
            chk($sformatf("late rvalid rd %0d", i), rd, 0);
        end
        dm_rvalid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
